// File: rtl/rca_bist_pkg.sv
// rtl/rca_bist_pkg.sv - shared types and MISR constants for the adder BIST controller
package rca_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MISR_W = 5;

    // Marks the x^2 term of x^5+x^2+1; the x^0 term is the rotate into bit 0.
    localparam logic [MISR_W-1:0] MISR_TAP = 5'b00100;

endpackage

// File: rtl/rca_bist_misr.sv
// rtl/rca_bist_misr.sv - multiple-input signature register compacting adder responses
module rca_bist_misr
    import rca_bist_pkg::*;
#(
    parameter int                WIDTH = MISR_W,
    parameter logic [WIDTH-1:0]  TAP   = WIDTH'(MISR_TAP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_nxt
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    // Shift with MSB feedback into bit 0 and every tapped bit, then fold in the response.
    always_comb begin
        sig_nxt = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]}
                ^ (TAP & {WIDTH{sig_q[WIDTH-1]}})
                ^ resp;
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = sig_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/rca_bist_ctrl.sv
// rtl/rca_bist_ctrl.sv - BIST sequencer, checker and result store for a ripple-carry adder
module rca_bist_ctrl
    import rca_bist_pkg::*;
#(
    parameter int          W         = 4,
    parameter int          N_PAT     = 8,
    parameter bit          CHECK_SIG = 1'b0,
    parameter logic [W:0]  SIG_GOLD  = '0
) (
    input  logic                       clk,
    input  logic                       init_n,
    input  logic                       start,
    input  logic [W-1:0]               at,
    input  logic [W-1:0]               bt,
    input  logic                       cint,
    input  logic [W-1:0]               sum,
    input  logic                       cout,
    output logic                       tpg_init,
    output logic                       test,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(N_PAT+1)-1:0] fail_cnt,
    output logic [$clog2(N_PAT)-1:0]   first_fail,
    output logic [W:0]                 sig
);

    localparam int CW = $clog2(N_PAT + 1);
    localparam int IW = $clog2(N_PAT);
    localparam logic [IW-1:0] LAST = IW'(N_PAT - 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  fail_cnt_q, fail_cnt_d;
    logic [IW-1:0]  first_fail_q, first_fail_d;
    logic           tpg_init_q, tpg_init_d;
    logic           test_q, test_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;

    logic           misr_clr;
    logic           misr_en;
    logic [W:0]     resp;
    logic [W:0]     expected;
    logic [W:0]     sig_nxt;

    assign resp     = {cout, sum};
    assign expected = {1'b0, at} + {1'b0, bt} + (W+1)'(cint);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        tpg_init_d   = tpg_init_q;
        test_d       = test_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        misr_clr     = 1'b0;
        misr_en      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    idx_d        = '0;
                    fail_cnt_d   = '0;
                    first_fail_d = '0;
                    misr_clr     = 1'b1;
                    tpg_init_d   = 1'b0;
                    test_d       = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            RUN: begin
                misr_en = 1'b1;
                idx_d   = idx_q + 1'b1;
                if (resp != expected) begin
                    fail_cnt_d = fail_cnt_q + 1'b1;
                    if (fail_cnt_q == '0) begin
                        first_fail_d = idx_q;
                    end
                end
                // tpg_init rises on the same edge as the last sample so the TPG is parked at 0.
                if (idx_q == LAST) begin
                    state_d    = DONE;
                    idx_d      = '0;
                    tpg_init_d = 1'b1;
                    test_d     = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = (fail_cnt_d == '0) && (!CHECK_SIG || (sig_nxt == SIG_GOLD));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            tpg_init_q   <= 1'b1;
            test_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            tpg_init_q   <= tpg_init_d;
            test_q       <= test_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    rca_bist_misr #(
        .WIDTH (W + 1),
        .TAP   ((W+1)'(MISR_TAP))
    ) u_misr (
        .clk     (clk),
        .rst_n   (init_n),
        .clr     (misr_clr),
        .en      (misr_en),
        .resp    (resp),
        .sig     (sig),
        .sig_nxt (sig_nxt)
    );

    assign tpg_init   = tpg_init_q;
    assign test       = test_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_cnt   = fail_cnt_q;
    assign first_fail = first_fail_q;

endmodule
